// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg -- shared definitions for the frequency meter.
//
// Contents:
//   state_t          FSM encoding (IDLE, MEASURE, LATCH, CONVERT)
//   DEF_GATE_CYCLES  default gate window length in clk cycles (1 s at 50 MHz)
//   DEF_CNT_W        default edge counter / result width
//   BCD_DIGITS       number of BCD digits in the optional decimal output
//   BCD_W            width of the BCD output (4 bits per digit)
//   bcd_adjust()     add-3 correction step of the shift-add-3 converter
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LATCH   = 2'd2,
    ST_CONVERT = 2'd3
  } state_t;

  localparam int DEF_GATE_CYCLES = 50_000_000;
  localparam int DEF_CNT_W       = 26;
  localparam int BCD_DIGITS      = 8;
  localparam int BCD_W           = 4 * BCD_DIGITS;

  // Every digit of 5 or more gets 3 added, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd[4*d +: 4] > 4'd4) res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/freq_meter_bin2bcd_seq.sv
// bin2bcd_seq -- sequential shift-add-3 (double dabble) binary to BCD
// converter. Present only when FREQ_METER_BCD_EN is defined.
//
// Parameters:
//   CNT_W   width of the binary input
// Ports:
//   clk     clock
//   rstn    asynchronous active-low reset
//   start   one-cycle request; bin is sampled in the same cycle
//   bin     binary value to convert
//   busy    high while shift steps remain
//   done    one-cycle pulse; bcd holds the final result in that cycle
//   bcd     BCD_W-bit packed BCD result, digit 0 in [3:0]
//
// The first shift happens on the start edge itself, so the last of the
// CNT_W shifts lands CNT_W-1 cycles after start and done is visible
// CNT_W cycles after the start cycle.
`ifdef FREQ_METER_BCD_EN
module bin2bcd_seq
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int REM_W = $clog2(CNT_W + 1);

  logic [CNT_W-1:0]       bin_sh;
  logic [REM_W-1:0]       rem;
  logic [BCD_W+CNT_W-1:0] src;
  logic [BCD_W+CNT_W-1:0] shifted;

  // A fresh start begins from an all-zero BCD accumulator.
  assign src     = start ? {{BCD_W{1'b0}}, bin} : {bcd, bin_sh};
  assign shifted = {bcd_adjust(src[CNT_W +: BCD_W]), src[CNT_W-1:0]} << 1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcd    <= '0;
      bin_sh <= '0;
      rem    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        bcd    <= shifted[CNT_W +: BCD_W];
        bin_sh <= shifted[CNT_W-1:0];
      end
      if (start) begin
        if (CNT_W == 1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          busy <= 1'b1;
          rem  <= REM_W'(CNT_W - 1);
        end
      end else if (busy) begin
        rem <= rem - REM_W'(1);
        if (rem == REM_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/freq_meter.sv
// freq_meter -- gated-window frequency meter.
//
// Counts rising edges of an asynchronous square wave over a window of
// GATE_CYCLES clk cycles. Windows run back to back with a single LATCH
// cycle of dead time between them, and the count of each completed
// window is published on freq_o with a one-cycle valid_o pulse.
//
// Parameters:
//   GATE_CYCLES  gate window length in clk cycles
//   CNT_W        width of the edge counter and of freq_o
// Ports:
//   clk      clock (20 ns)
//   rstn     asynchronous active-low reset
//   en       measurement enable; low holds / returns the block to IDLE
//   sig_in   square wave to measure, asynchronous to clk
//   freq_o   edge count of the last completed window
//   valid_o  one-cycle pulse when freq_o (and bcd_o) update
//   ovf_o    the last window saturated the edge counter
//   gate_o   high while a gate window is open
//   bcd_o    (FREQ_METER_BCD_EN only) freq_o as 8 BCD digits
//
// Build option: define FREQ_METER_BCD_EN to add bcd_o. The result then
// goes through a CNT_W-cycle converter while the next window is already
// running, so GATE_CYCLES must exceed CNT_W+2.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             gate_o
`ifdef FREQ_METER_BCD_EN
  ,
  output logic [BCD_W-1:0] bcd_o
`endif
);

  localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // --------------------------------------------------------------------
  // Input synchronizer and rising-edge detector. sync[1:0] is the
  // two-flop synchronizer; sync[2] is the history flop for detection.
  // --------------------------------------------------------------------
  logic [2:0] sync;
  logic       edge_det;

  // NOTE: clocked state uses non-blocking (<=) so each flop takes the
  // value from before the edge; with blocking assignments the three
  // stages would collapse into a single flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync <= '0;
    else       sync <= {sync[1:0], sig_in};
  end

  assign edge_det = sync[1] & ~sync[2];

  // --------------------------------------------------------------------
  // Gate FSM with the gate and edge counters.
  // --------------------------------------------------------------------
  state_t           state;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              sat;
  logic              latch_fire;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      gate_o   <= 1'b0;
    end else begin
      case (state)
        // IDLE and LATCH both open a fresh window when enabled; LATCH is
        // the single dead cycle between back-to-back windows.
        ST_IDLE, ST_LATCH: begin
          if (en) begin
            state    <= ST_MEASURE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            gate_o   <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_MEASURE: begin
          if (!en) begin
            // Abort: the partial count is simply never latched.
            state  <= ST_IDLE;
            gate_o <= 1'b0;
          end else begin
            if (edge_det) begin
              // Saturate instead of wrapping; sat records a lost edge.
              if (edge_cnt == CNT_MAX) sat <= 1'b1;
              else                     edge_cnt <= edge_cnt + CNT_W'(1);
            end
            if (gate_cnt == GATE_LAST) begin
              state  <= ST_LATCH;
              gate_o <= 1'b0;
            end else begin
              gate_cnt <= gate_cnt + GATE_W'(1);
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          gate_o <= 1'b0;
        end
      endcase
    end
  end

  // Edge and gate counters stay frozen through LATCH, so this cycle sees
  // the final count of the window that just closed.
  assign latch_fire = (state == ST_LATCH);

  // --------------------------------------------------------------------
  // Result publication.
  // --------------------------------------------------------------------
`ifdef FREQ_METER_BCD_EN
  logic [CNT_W-1:0] pend_freq;
  logic             pend_ovf;
  state_t           conv_state;
  logic             conv_busy;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic             commit;

  bin2bcd_seq #(
    .CNT_W(CNT_W)
  ) u_bin2bcd (
    .clk  (clk),
    .rstn (rstn),
    .start(latch_fire),
    .bin  (edge_cnt),
    .busy (conv_busy),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  assign commit = (conv_state == ST_CONVERT) && conv_done && !conv_busy;

  // The binary result and flag are parked until the decimal form is
  // ready, so freq_o, ovf_o and bcd_o always change together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_freq  <= '0;
      pend_ovf   <= 1'b0;
      conv_state <= ST_IDLE;
      freq_o     <= '0;
      ovf_o      <= 1'b0;
      bcd_o      <= '0;
      valid_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (latch_fire) begin
        pend_freq  <= edge_cnt;
        pend_ovf   <= sat;
        conv_state <= ST_CONVERT;
      end else if (commit) begin
        freq_o     <= pend_freq;
        ovf_o      <= pend_ovf;
        bcd_o      <= conv_bcd;
        valid_o    <= 1'b1;
        conv_state <= ST_IDLE;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      freq_o  <= '0;
      ovf_o   <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= latch_fire;
      if (latch_fire) begin
        freq_o <= edge_cnt;
        ovf_o  <= sat;
      end
    end
  end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter -- self-checking bench for freq_meter.
//
// Two instances share clk, rstn and sig_in: dut (CNT_W=26) and dut_sat
// (CNT_W=4, for saturation). Expected results are pushed to a per-DUT
// queue before a window runs and popped by a monitor on every valid_o.
// Works with and without FREQ_METER_BCD_EN.
module tb_freq_meter;
  import freq_meter_pkg::*;

  localparam int GATE = 100;
  localparam int CW   = 26;
  localparam int CWS  = 4;
`ifdef FREQ_METER_BCD_EN
  localparam int LAT_EXTRA   = CW;
  localparam int LAT_EXTRA_S = CWS;
`else
  localparam int LAT_EXTRA   = 0;
  localparam int LAT_EXTRA_S = 0;
`endif
  // en raised in cycle R: window is R+1..R+100, LATCH R+101, valid R+102.
  localparam int FIRST_LAT = GATE + 2;

  typedef struct packed {
    logic [31:0] freq;
    logic        ovf;
    logic [31:0] bcd;
  } exp_t;

  logic            clk;
  logic            rstn;
  logic            en;
  logic            en_s;
  logic            sig;
  logic [CW-1:0]   freq;
  logic            valid;
  logic            ovf;
  logic            gate;
  logic [CWS-1:0]  freq_s;
  logic            valid_s;
  logic            ovf_s;
  logic            gate_s;
`ifdef FREQ_METER_BCD_EN
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_s;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nvalid = 0;
  int   nvalid_s = 0;
  int   last_vcyc = 0;
  int   last_vcyc_s = 0;
  int   gap = 0;
  int   period = 0;
  logic level = 1'b0;
  int   ph = 0;
  exp_t q[$];
  exp_t qs[$];

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .sig_in(sig),
    .freq_o(freq), .valid_o(valid), .ovf_o(ovf), .gate_o(gate)
`ifdef FREQ_METER_BCD_EN
    , .bcd_o(bcd)
`endif
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(CWS)) dut_sat (
    .clk(clk), .rstn(rstn), .en(en_s), .sig_in(sig),
    .freq_o(freq_s), .valid_o(valid_s), .ovf_o(ovf_s), .gate_o(gate_s)
`ifdef FREQ_METER_BCD_EN
    , .bcd_o(bcd_s)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Square-wave source, updated on the falling edge; period 0 holds level.
  initial begin
    sig = 1'b0;
    forever begin
      @(negedge clk);
      if (period == 0) sig = level;
      else begin
        ph  = (ph + 1) % period;
        sig = (ph < period / 2);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic push(input bit s, input int f, input bit o);
    exp_t e;
    e.freq = 32'(f);
    e.ovf  = o;
    e.bcd  = to_bcd(f);
    if (s) qs.push_back(e);
    else   q.push_back(e);
  endtask

  // Main sequence acts just after the falling edge, after the monitors.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input bit s, input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (((s ? nvalid_s : nvalid) < target) && (n < budget)) begin
      tick();
      n++;
    end
    check(tag, s ? nvalid_s : nvalid, target);
  endtask

  // Scoreboard monitors.
  initial begin : mon_main
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        nvalid++;
        gap       = cyc - last_vcyc;
        last_vcyc = cyc;
        if (q.size() == 0) check("main_unexpected_valid", q.size(), 1);
        else begin
          e = q.pop_front();
          check("main_freq", 32'(freq), e.freq);
          check("main_ovf", 32'(ovf), 32'(e.ovf));
`ifdef FREQ_METER_BCD_EN
          check("main_bcd", bcd, e.bcd);
`endif
        end
      end
    end
  end

  initial begin : mon_sat
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_s === 1'b1) begin
        nvalid_s++;
        last_vcyc_s = cyc;
        if (qs.size() == 0) check("sat_unexpected_valid", qs.size(), 1);
        else begin
          e = qs.pop_front();
          check("sat_freq", 32'(freq_s), e.freq);
          check("sat_ovf", 32'(ovf_s), 32'(e.ovf));
`ifdef FREQ_METER_BCD_EN
          check("sat_bcd", bcd_s, e.bcd);
`endif
        end
      end
    end
  end

  initial begin : stim
    int r;
    int n0;
    int n;
    rstn = 1'b0;
    en   = 1'b0;
    en_s = 1'b0;

    // Reset state.
    ticks(3);
    check("rst_freq", 32'(freq), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_gate", 32'(gate), 0);
    rstn = 1'b1;
    ticks(10);
    check("idle_gate", 32'(gate), 0);
    check("idle_no_valid", nvalid, 0);

    // Period 10: three back-to-back windows of 10 edges.
    period = 10;
    ticks(30);
    push(0, 10, 0);
    en = 1'b1;
    r  = cyc;
    wait_valid(0, 1, GATE + LAT_EXTRA + 50, "p10_first_timeout");
    check("p10_first_latency", last_vcyc - r, FIRST_LAT + LAT_EXTRA);
    check("p10_gate_open", 32'(gate), 1);
    push(0, 10, 0);
    push(0, 10, 0);
    wait_valid(0, 3, 2 * (GATE + 1) + 50, "p10_b2b_timeout");
    check("p10_window_period", gap, GATE + 1);
    en = 1'b0;
    ticks(2);
    check("p10_gate_closed", 32'(gate), 0);

    // Abort at window cycle 50: no valid, result retained.
    en = 1'b1;
    ticks(50);
    en = 1'b0;
    n0 = nvalid;
    ticks(2 * GATE);
    check("abort_no_valid", nvalid, n0);
    check("abort_freq_kept", 32'(freq), 10);
    check("abort_ovf_kept", 32'(ovf), 0);

    // Constant low, then constant high: zero count, valid still pulses.
    period = 0;
    level  = 1'b0;
    ticks(20);
    push(0, 0, 0);
    push(0, 0, 0);
    en = 1'b1;
    wait_valid(0, n0 + 2, 2 * (GATE + 1) + LAT_EXTRA + 50, "low_timeout");
    check("low_window_period", gap, GATE + 1);
    en = 1'b0;
    level = 1'b1;
    ticks(10);
    push(0, 0, 0);
    en = 1'b1;
    wait_valid(0, n0 + 3, GATE + LAT_EXTRA + 50, "high_timeout");
    en = 1'b0;

    // Re-raise after abort with period 4: full new window, 25 edges.
    period = 4;
    ticks(20);
    push(0, 25, 0);
    n0 = nvalid;
    en = 1'b1;
    r  = cyc;
    wait_valid(0, n0 + 1, GATE + LAT_EXTRA + 50, "p4_timeout");
    check("p4_latency", last_vcyc - r, FIRST_LAT + LAT_EXTRA);
    en = 1'b0;

    // Reset mid-window: outputs clear at once, full window after release.
    period = 10;
    ticks(30);
    en = 1'b1;
    ticks(40);
    rstn = 1'b0;
    #1;
    check("midrst_freq", 32'(freq), 0);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_ovf", 32'(ovf), 0);
    check("midrst_gate", 32'(gate), 0);
`ifdef FREQ_METER_BCD_EN
    check("midrst_bcd", bcd, 0);
`endif
    ticks(3);
    n = 0;
    while ((sig !== 1'b0) && (n < 20)) begin
      tick();
      n++;
    end
    push(0, 10, 0);
    n0   = nvalid;
    rstn = 1'b1;
    r    = cyc;
    wait_valid(0, n0 + 1, GATE + LAT_EXTRA + 50, "postrst_timeout");
    check("postrst_latency", last_vcyc - r, FIRST_LAT + LAT_EXTRA);
    en = 1'b0;

    // Saturation with CNT_W=4: 25 edges clamp to 15, then an idle window.
    period = 4;
    ticks(20);
    push(1, 15, 1);
    en_s = 1'b1;
    r    = cyc;
    wait_valid(1, 1, GATE + LAT_EXTRA_S + 50, "sat_timeout");
    check("sat_latency", last_vcyc_s - r, FIRST_LAT + LAT_EXTRA_S);
    en_s   = 1'b0;
    period = 0;
    level  = 1'b0;
    ticks(10);
    push(1, 0, 0);
    en_s = 1'b1;
    wait_valid(1, 2, GATE + LAT_EXTRA_S + 50, "sat_idle_timeout");
    en_s = 1'b0;
    ticks(5);

    check("main_queue_drained", q.size(), 0);
    check("sat_queue_drained", qs.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
